// File: rtl/insa_ovf_pkg.sv
// Shared types and default sizes for the heap-overflow tracker and its range store.
// OVF_MERGE_EN selects overlap/adjacency merging in ovf_range_store.
package insa_ovf_pkg;

  localparam int OVF_NR_ENTRIES = 8;
  localparam int OVF_ADDR_W     = 32;

  typedef struct packed {
    logic                  valid;
    logic [OVF_ADDR_W-1:0] first;
    logic [OVF_ADDR_W-1:0] last;
  } ovf_range_t;

endpackage

// File: rtl/ovf_range_store_if.sv
// Write/query bundle between the overflow tracker (master) and the range store (slave).
// There is no handshake: a write is taken in any cycle wr_en_i is high, queries are combinational.
interface ovf_range_store_if #(
  parameter int NrEntries = 8,
  parameter int AddrWidth = 32
);
  logic                         clear_i;
  logic                         wr_en_i;
  logic [AddrWidth-1:0]         wr_first_i;
  logic [AddrWidth-1:0]         wr_last_i;
  logic [AddrWidth-1:0]         find_addr_i;
  logic [AddrWidth-1:0]         base_addr_i;
  logic                         addr_in_range_o;
  logic                         addr_is_first_o;
  logic                         read_overflow_o;
  logic [31:0]                  read_o;
  logic [31:0]                  read2_o;
  logic [$clog2(NrEntries):0]   count_o;
  logic                         full_o;

  modport master (
    output clear_i, wr_en_i, wr_first_i, wr_last_i, find_addr_i, base_addr_i,
    input  addr_in_range_o, addr_is_first_o, read_overflow_o, read_o, read2_o, count_o, full_o
  );

  modport slave (
    input  clear_i, wr_en_i, wr_first_i, wr_last_i, find_addr_i, base_addr_i,
    output addr_in_range_o, addr_is_first_o, read_overflow_o, read_o, read2_o, count_o, full_o
  );
endinterface

// File: rtl/ovf_range_match.sv
// Per-entry comparators: query hits and, with OVF_MERGE_EN, whether the incoming write touches it.
module ovf_range_match #(
  parameter int AddrWidth = 32
) (
  input  logic                 valid,
  input  logic [AddrWidth-1:0] first,
  input  logic [AddrWidth-1:0] last,
  input  logic [AddrWidth-1:0] find_addr,
  input  logic [AddrWidth-1:0] base_addr,
  input  logic [AddrWidth-1:0] wr_first,
  input  logic [AddrWidth-1:0] wr_last,
  output logic                 in_range,
  output logic                 is_first,
  output logic                 rd_ovf,
  output logic                 touches
);

  assign in_range = valid && (find_addr >= first) && (find_addr <= last);
  assign is_first = valid && (find_addr == first);
  assign rd_ovf   = valid && (base_addr == first) && (find_addr > last);

`ifdef OVF_MERGE_EN
  // One extra bit so last+1 / wr_last+1 never wrap at all-ones addresses.
  logic [AddrWidth:0] last_p1;
  logic [AddrWidth:0] wr_last_p1;
  assign last_p1    = {1'b0, last} + 1'b1;
  assign wr_last_p1 = {1'b0, wr_last} + 1'b1;
  assign touches    = valid && ({1'b0, wr_first} <= last_p1) && (wr_last_p1 >= {1'b0, first});
`else
  logic unused_wr;
  assign unused_wr = ^{wr_first, wr_last};
  assign touches   = 1'b0;
`endif

endmodule

// File: rtl/ovf_range_store.sv
// Circular store of overflowed address ranges with combinational lookups.
// Define OVF_MERGE_EN to merge a write into the lowest-index touching entry instead of allocating.
module ovf_range_store
  import insa_ovf_pkg::*;
#(
  parameter int NrEntries = OVF_NR_ENTRIES,
  parameter int AddrWidth = OVF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  ovf_range_store_if.slave  bus
);

  localparam int IdxW = $clog2(NrEntries);
  localparam int CntW = IdxW + 1;

  logic [NrEntries-1:0]                valid_q;
  logic [NrEntries-1:0][AddrWidth-1:0] first_q;
  logic [NrEntries-1:0][AddrWidth-1:0] last_q;
  logic [IdxW-1:0]                     wr_ptr_q;
  logic [IdxW-1:0]                     last_idx_q;
  logic [CntW-1:0]                     count_q;

  logic [NrEntries-1:0] in_range;
  logic [NrEntries-1:0] is_first;
  logic [NrEntries-1:0] rd_ovf;
  logic [NrEntries-1:0] touches;
  logic                 wr_ok;

  for (genvar gi = 0; gi < NrEntries; gi++) begin : g_match
    ovf_range_match #(.AddrWidth(AddrWidth)) u_match (
      .valid     (valid_q[gi]),
      .first     (first_q[gi]),
      .last      (last_q[gi]),
      .find_addr (bus.find_addr_i),
      .base_addr (bus.base_addr_i),
      .wr_first  (bus.wr_first_i),
      .wr_last   (bus.wr_last_i),
      .in_range  (in_range[gi]),
      .is_first  (is_first[gi]),
      .rd_ovf    (rd_ovf[gi]),
      .touches   (touches[gi])
    );
  end

  assign wr_ok = bus.wr_en_i && (bus.wr_first_i <= bus.wr_last_i);

`ifdef OVF_MERGE_EN
  logic                 merge_hit;
  logic [IdxW-1:0]      merge_idx;
  logic [AddrWidth-1:0] merged_first;
  logic [AddrWidth-1:0] merged_last;

  // Lowest touching index wins; scanning downward leaves it last-assigned.
  always_comb begin
    merge_hit = |touches;
    merge_idx = '0;
    for (int i = NrEntries - 1; i >= 0; i--) begin
      if (touches[i]) merge_idx = IdxW'(i);
    end
  end

  assign merged_first = (bus.wr_first_i < first_q[merge_idx]) ? bus.wr_first_i : first_q[merge_idx];
  assign merged_last  = (bus.wr_last_i  > last_q[merge_idx])  ? bus.wr_last_i  : last_q[merge_idx];
`else
  logic unused_touches;
  assign unused_touches = ^touches;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      first_q    <= '0;
      last_q     <= '0;
      wr_ptr_q   <= '0;
      last_idx_q <= '0;
      count_q    <= '0;
    end else if (bus.clear_i) begin
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      last_idx_q <= '0;
      count_q    <= '0;
    end else if (wr_ok) begin
`ifdef OVF_MERGE_EN
      if (merge_hit) begin
        first_q[merge_idx] <= merged_first;
        last_q[merge_idx]  <= merged_last;
        last_idx_q         <= merge_idx;
      end else
`endif
      begin
        // Oldest slot is overwritten once full; wr_ptr wraps as NrEntries is a power of two.
        valid_q[wr_ptr_q] <= 1'b1;
        first_q[wr_ptr_q] <= bus.wr_first_i;
        last_q[wr_ptr_q]  <= bus.wr_last_i;
        last_idx_q        <= wr_ptr_q;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
        if (count_q != CntW'(NrEntries)) count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.addr_in_range_o = |in_range;
  assign bus.addr_is_first_o = |is_first;
  assign bus.read_overflow_o = |rd_ovf;
  assign bus.read_o          = 32'(first_q[last_idx_q]);
  assign bus.read2_o         = 32'(last_q[last_idx_q]);
  assign bus.count_o         = count_q;
  assign bus.full_o          = (count_q == CntW'(NrEntries));

endmodule
